// File: rtl/multicycle_ctrl_unit.sv
// Main FSM and ALU decoder for the multicycle RV32I datapath.
// Define MC_CTRL_BNE_EN so the branch state also executes bne (funct3=001).
module multicycle_ctrl_unit #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StExecI    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10,
    StHalt     = 4'd11
  } state_e;

  state_e state_q, state_d, out_st;

  logic branch_ok, op_legal;
  logic pc_update, branch, branch_take;
  logic mem_write_raw, ir_write_raw, reg_write_raw;
  logic [1:0] alu_op;

  // Opcode legality, including which branch flavours the BEQ state can execute.
  always_comb begin
    branch_ok = (funct3 == 3'b000);
`ifdef MC_CTRL_BNE_EN
    branch_ok = branch_ok | (funct3 == 3'b001);
`endif
    op_legal = (op == OpLoad) | (op == OpStore) | (op == OpRType) | (op == OpIType) |
               (op == OpJal) | ((op == OpBranch) & branch_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        if ((op == OpLoad) || (op == OpStore)) begin
          state_d = StMemAdr;
        end else if (op == OpRType) begin
          state_d = StExecR;
        end else if (op == OpIType) begin
          state_d = StExecI;
        end else if (op == OpJal) begin
          state_d = StJal;
        end else if ((op == OpBranch) && branch_ok) begin
          state_d = StBeq;
        end else begin
          state_d = HALT_ON_ILLEGAL ? StHalt : StFetch;
        end
      end
      StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
      StMemRead:  state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StJal:      state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StHalt:     state_d = StHalt;
      default:    state_d = StFetch;
    endcase
  end

  // During reset the datapath controls look like FETCH; enables are masked below.
  assign out_st = rst ? StFetch : state_q;

  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (out_st)
      StFetch: begin
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_update    = 1'b1;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      StMemRead: adr_src = 1'b1;
      StMemWb: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      StMemWrite: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      StAluWb: reg_write_raw = 1'b1;
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      StBeq: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MC_CTRL_BNE_EN
  // funct3[0] inverts the sense of Zero, turning beq into bne.
  assign branch_take = branch & (zero ^ funct3[0]);
`else
  assign branch_take = branch & zero;
`endif

  assign pc_write   = ~rst & (pc_update | branch_take);
  assign mem_write  = ~rst & mem_write_raw;
  assign ir_write   = ~rst & ir_write_raw;
  assign reg_write  = ~rst & reg_write_raw;
  assign illegal_op = ~rst & (state_q == StDecode) & ~op_legal;
  assign state      = state_q;

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b100:  alu_control = 3'b100;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OpStore:  imm_src = 2'b01;
      OpBranch: imm_src = 2'b10;
      OpJal:    imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Self-checking bench for multicycle_ctrl_unit: vector table, reset/halt sequences and
// randomized instruction streams against a path-and-table reference model.
module tb_multicycle_ctrl_unit;

`ifdef MC_CTRL_BNE_EN
  localparam bit BneEn = 1'b1;
`else
  localparam bit BneEn = 1'b0;
`endif

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpJal = 7'b1101111;
  localparam logic [6:0] OpBr  = 7'b1100011;
  localparam logic [6:0] OpBad = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] op = OpR;
  logic [2:0] funct3 = 3'd0;
  logic funct7b5 = 1'b0;
  logic zero = 1'b0;

  logic a_pc_write, a_adr_src, a_mem_write, a_ir_write, a_reg_write, a_illegal_op;
  logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b, a_imm_src;
  logic [2:0] a_alu_control;
  logic [3:0] a_state;
  logic h_pc_write, h_adr_src, h_mem_write, h_ir_write, h_reg_write, h_illegal_op;
  logic [1:0] h_result_src, h_alu_src_a, h_alu_src_b, h_imm_src;
  logic [2:0] h_alu_control;
  logic [3:0] h_state;

  always #5 clk = ~clk;

  multicycle_ctrl_unit #(.HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(a_pc_write), .adr_src(a_adr_src), .mem_write(a_mem_write),
    .ir_write(a_ir_write), .reg_write(a_reg_write), .result_src(a_result_src),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .imm_src(a_imm_src),
    .alu_control(a_alu_control), .illegal_op(a_illegal_op), .state(a_state)
  );

  multicycle_ctrl_unit #(.HALT_ON_ILLEGAL(1'b1)) dut_halt (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(h_pc_write), .adr_src(h_adr_src), .mem_write(h_mem_write),
    .ir_write(h_ir_write), .reg_write(h_reg_write), .result_src(h_result_src),
    .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b), .imm_src(h_imm_src),
    .alu_control(h_alu_control), .illegal_op(h_illegal_op), .state(h_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] act0();
    return {a_pc_write, a_adr_src, a_mem_write, a_ir_write, a_reg_write, a_result_src,
            a_alu_src_a, a_alu_src_b, a_imm_src, a_alu_control, a_illegal_op};
  endfunction

  function automatic logic [16:0] act1();
    return {h_pc_write, h_adr_src, h_mem_write, h_ir_write, h_reg_write, h_result_src,
            h_alu_src_a, h_alu_src_b, h_imm_src, h_alu_control, h_illegal_op};
  endfunction

  function automatic logic legal(input logic [6:0] o, input logic [2:0] f3);
    return (o == OpLw) || (o == OpSw) || (o == OpR) || (o == OpI) || (o == OpJal) ||
           ((o == OpBr) && ((f3 == 3'd0) || (BneEn && (f3 == 3'd1))));
  endfunction

  function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3,
                                           input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Sequence of states visited by one instruction, first state in the low nibble.
  function automatic logic [19:0] path_of(input logic [6:0] o, input logic [2:0] f3,
                                          output int len);
    logic [19:0] p;
    len = 2;
    p = 20'h00010;
    if (o == OpLw) begin
      len = 5; p = 20'h43210;
    end else if (o == OpSw) begin
      len = 4; p = 20'h05210;
    end else if (o == OpR) begin
      len = 4; p = 20'h07610;
    end else if (o == OpI) begin
      len = 4; p = 20'h07810;
    end else if (o == OpJal) begin
      len = 4; p = 20'h07910;
    end else if (legal(o, f3)) begin
      len = 3; p = 20'h00A10;
    end
    return p;
  endfunction

  function automatic logic [16:0] exp_out(input int st, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input logic r);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    int s;
    s = r ? 0 : st;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    res = 0; sa = 0; sb = 0; alu = 0;
    imm = (o == OpSw) ? 2'b01 : (o == OpBr) ? 2'b10 : (o == OpJal) ? 2'b11 : 2'b00;
    case (s)
      0:  begin irw = 1; sb = 2; res = 2; pcw = 1; end
      1:  begin sa = 1; sb = 1; ill = !legal(o, f3); end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin res = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; alu = funct_alu(o, f3, f7); end
      7:  rw = 1;
      8:  begin sa = 2; sb = 1; alu = funct_alu(o, f3, f7); end
      9:  begin sa = 1; sb = 2; pcw = 1; end
      10: begin sa = 2; alu = 3'b001; pcw = BneEn ? (z ^ f3[0]) : z; end
      default: ;
    endcase
    if (r) begin
      pcw = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    end
    return {pcw, adr, mw, irw, rw, res, sa, sb, imm, alu, ill};
  endfunction

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [19:0] path;
    logic [2:0]  len;
    logic [2:0]  alu2;
    logic        pc_last;
    logic        ill;
  } vec_t;

  localparam int NumVec = 17;
  vec_t tbl [NumVec];

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [19:0] p;
    int len;
    int k;
    logic [6:0] r_op;
    logic [2:0] r_f3;
    logic r_f7;

    tbl[0]  = '{OpR,   3'd0, 1'b0, 1'b0, 20'h07610, 3'd4, 3'b000, 1'b0, 1'b0};
    tbl[1]  = '{OpR,   3'd0, 1'b1, 1'b1, 20'h07610, 3'd4, 3'b001, 1'b0, 1'b0};
    tbl[2]  = '{OpR,   3'd7, 1'b0, 1'b0, 20'h07610, 3'd4, 3'b010, 1'b0, 1'b0};
    tbl[3]  = '{OpR,   3'd6, 1'b0, 1'b0, 20'h07610, 3'd4, 3'b011, 1'b0, 1'b0};
    tbl[4]  = '{OpR,   3'd4, 1'b0, 1'b0, 20'h07610, 3'd4, 3'b100, 1'b0, 1'b0};
    tbl[5]  = '{OpR,   3'd2, 1'b0, 1'b0, 20'h07610, 3'd4, 3'b101, 1'b0, 1'b0};
    tbl[6]  = '{OpR,   3'd1, 1'b1, 1'b0, 20'h07610, 3'd4, 3'b000, 1'b0, 1'b0};
    tbl[7]  = '{OpI,   3'd0, 1'b1, 1'b0, 20'h07810, 3'd4, 3'b000, 1'b0, 1'b0};
    tbl[8]  = '{OpI,   3'd4, 1'b0, 1'b0, 20'h07810, 3'd4, 3'b100, 1'b0, 1'b0};
    tbl[9]  = '{OpLw,  3'd2, 1'b0, 1'b0, 20'h43210, 3'd5, 3'b000, 1'b0, 1'b0};
    tbl[10] = '{OpSw,  3'd2, 1'b0, 1'b0, 20'h05210, 3'd4, 3'b000, 1'b0, 1'b0};
    tbl[11] = '{OpJal, 3'd0, 1'b0, 1'b0, 20'h07910, 3'd4, 3'b000, 1'b0, 1'b0};
    tbl[12] = '{OpBr,  3'd0, 1'b0, 1'b1, 20'h00A10, 3'd3, 3'b001, 1'b1, 1'b0};
    tbl[13] = '{OpBr,  3'd0, 1'b0, 1'b0, 20'h00A10, 3'd3, 3'b001, 1'b0, 1'b0};
    tbl[14] = '{OpBad, 3'd0, 1'b0, 1'b0, 20'h00010, 3'd2, 3'b000, 1'b0, 1'b1};
`ifdef MC_CTRL_BNE_EN
    tbl[15] = '{OpBr,  3'd1, 1'b0, 1'b0, 20'h00A10, 3'd3, 3'b001, 1'b1, 1'b0};
    tbl[16] = '{OpBr,  3'd1, 1'b0, 1'b1, 20'h00A10, 3'd3, 3'b001, 1'b0, 1'b0};
`else
    tbl[15] = '{OpBr,  3'd1, 1'b0, 1'b0, 20'h00010, 3'd2, 3'b000, 1'b0, 1'b1};
    tbl[16] = '{OpBr,  3'd1, 1'b0, 1'b1, 20'h00010, 3'd2, 3'b000, 1'b0, 1'b1};
`endif

    // Reset held across two rising edges; inputs change on negedge, sampled 4ns later.
    rst = 1'b1;
    #4;
    chk("reset enables edge0", 32'({a_pc_write, a_ir_write, a_reg_write, a_mem_write,
                                    a_illegal_op}), 32'd0);
    @(negedge clk); #4;
    chk("reset state", 32'(a_state), 32'd0);
    chk("reset enables edge1", 32'({a_pc_write, a_ir_write, a_reg_write, a_mem_write,
                                    a_illegal_op}), 32'd0);

    for (int v = 0; v < NumVec; v++) begin
      p = tbl[v].path;
      for (int c = 0; c < int'(tbl[v].len); c++) begin
        @(negedge clk);
        if (c == 0) begin
          rst = 1'b0;
          op = tbl[v].op; funct3 = tbl[v].f3; funct7b5 = tbl[v].f7; zero = tbl[v].z;
        end
        #4;
        chk($sformatf("tbl%0d state c%0d", v, c), 32'(a_state), 32'(p[4*c +: 4]));
        if (v == 0 && c == 0)
          chk("release ir_write/pc_write", 32'({a_ir_write, a_pc_write}), 32'd3);
        if (c == 1) chk($sformatf("tbl%0d illegal_op", v), 32'(a_illegal_op), 32'(tbl[v].ill));
        if (c == 2) chk($sformatf("tbl%0d alu_control", v), 32'(a_alu_control), 32'(tbl[v].alu2));
        if (c == int'(tbl[v].len) - 1)
          chk($sformatf("tbl%0d pc_write last", v), 32'(a_pc_write), 32'(tbl[v].pc_last));
        if (p[4*c +: 4] == 4'd7 || p[4*c +: 4] == 4'd4)
          chk($sformatf("tbl%0d reg_write wb", v), 32'(a_reg_write), 32'd1);
        else
          chk($sformatf("tbl%0d reg_write idle", v), 32'(a_reg_write), 32'd0);
      end
    end

    // sw interrupted by reset in MEMWRITE, then a clean sw.
    @(negedge clk); op = OpSw; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0; #4;
    chk("swrst state0", 32'(a_state), 32'd0);
    @(negedge clk); #4;
    chk("swrst state1", 32'(a_state), 32'd1);
    @(negedge clk); #4;
    chk("swrst state2", 32'(a_state), 32'd2);
    chk("swrst imm_src", 32'(a_imm_src), 32'd1);
    @(negedge clk); rst = 1'b1; #4;
    chk("swrst in memwrite", 32'(a_state), 32'd5);
    chk("swrst mem_write masked", 32'({a_mem_write, a_adr_src, a_ir_write}), 32'd0);
    @(negedge clk); rst = 1'b0; #4;
    chk("swrst back to fetch", 32'(a_state), 32'd0);
    chk("swrst fetch ir_write", 32'(a_ir_write), 32'd1);
    chk("swrst no write", 32'(a_mem_write), 32'd0);
    @(negedge clk); #4;
    chk("sw2 state1", 32'(a_state), 32'd1);
    @(negedge clk); #4;
    chk("sw2 state2", 32'(a_state), 32'd2);
    @(negedge clk); #4;
    chk("sw2 state5", 32'(a_state), 32'd5);
    chk("sw2 mem_write", 32'(a_mem_write), 32'd1);

    // Halting variant: illegal opcode parks the FSM until reset.
    @(negedge clk); rst = 1'b1; op = OpBad; funct3 = 3'd0; #4;
    @(negedge clk); #4;
    chk("halt reset state", 32'(h_state), 32'd0);
    @(negedge clk); rst = 1'b0; #4;
    chk("halt fetch", 32'(h_state), 32'd0);
    @(negedge clk); #4;
    chk("halt decode", 32'(h_state), 32'd1);
    chk("halt illegal_op", 32'(h_illegal_op), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #4;
      chk($sformatf("halt held %0d", i), 32'(h_state), 32'd11);
      chk($sformatf("halt outputs %0d", i), 32'(act1()), 32'd0);
    end
    @(negedge clk); rst = 1'b1; #4;
    chk("halt during rst", 32'(h_state), 32'd11);
    @(negedge clk); rst = 1'b0; #4;
    chk("halt released", 32'(h_state), 32'd0);

    // Randomized instruction stream with occasional mid-instruction resets.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b1;
    for (int n = 0; n < 250; n++) begin
      k = int'($urandom_range(0, 7));
      r_f3 = 3'($urandom_range(0, 7));
      r_f7 = 1'($urandom_range(0, 1));
      case (k)
        0: r_op = OpLw;
        1: r_op = OpSw;
        2: r_op = OpR;
        3: r_op = OpI;
        4: r_op = OpJal;
        5: begin r_op = OpBr; r_f3 = 3'($urandom_range(0, 2)); end
        6: r_op = OpBad;
        default: r_op = 7'($urandom);
      endcase
      p = path_of(r_op, r_f3, len);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if (c == 0) begin
          op = r_op; funct3 = r_f3; funct7b5 = r_f7;
        end
        zero = 1'($urandom_range(0, 1));
        rst = ($urandom_range(0, 39) == 0);
        #4;
        chk($sformatf("rnd%0d state c%0d op=%b", n, c, r_op), 32'(a_state), 32'(p[4*c +: 4]));
        chk($sformatf("rnd%0d outputs c%0d op=%b f3=%0d", n, c, r_op, r_f3), 32'(act0()),
            32'(exp_out(int'(p[4*c +: 4]), r_op, r_f3, r_f7, zero, rst)));
        if (rst) break;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
